// File: rtl/wb_modport_pkg.sv
// rtl/wb_modport_pkg.sv - shared widths, register addresses and reset values for wb_modport
package wb_modport_pkg;

    localparam int ADR_W  = 8;
    localparam int DATA_W = 32;

    localparam logic [ADR_W-1:0] ADR_CONFIG      = 8'h00;
    localparam logic [ADR_W-1:0] ADR_INT_PENDING = 8'h08;
    localparam logic [ADR_W-1:0] ADR_INT_STATUS  = 8'h0C;
    localparam logic [ADR_W-1:0] ADR_INT_MASK    = 8'h10;

    localparam logic [DATA_W-1:0] CFG_RST = 32'h0000_0001;

    // Registers are word aligned; the byte-lane bits of the address never select.
    function automatic logic adr_hit(input logic [ADR_W-1:0] adr, input logic [ADR_W-1:0] reg_adr);
        return adr[ADR_W-1:2] == reg_adr[ADR_W-1:2];
    endfunction

endpackage

// File: rtl/wb_modport_if.sv
// rtl/wb_modport_if.sv - Wishbone classic bus bundle with master/slave views
interface wb_modport_if;

    logic [wb_modport_pkg::ADR_W-1:0]  wb_adr_i;
    logic                              wb_cyc_i;
    logic                              wb_stb_i;
    logic                              wb_we_i;
    logic [wb_modport_pkg::DATA_W-1:0] wb_dat_i;
    logic                              wb_ack_o;
    logic [wb_modport_pkg::DATA_W-1:0] wb_dat_o;
    logic                              wb_int_o;

    modport master (
        output wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
        input  wb_ack_o, wb_dat_o, wb_int_o
    );

    modport slave (
        input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_dat_i,
        output wb_ack_o, wb_dat_o, wb_int_o
    );

endinterface

// File: rtl/wb_modport_int_ctrl.sv
// rtl/wb_modport_int_ctrl.sv - sticky pending bits, optional mask (WB_MODPORT_INT_MASK_EN), level irq
module wb_modport_int_ctrl #(
    parameter int NUM_INT = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_INT-1:0] evt,
    input  logic               rd_clr,
    input  logic               mask_we,
    input  logic [NUM_INT-1:0] mask_wdata,
    output logic [NUM_INT-1:0] pending,
    output logic [NUM_INT-1:0] mask,
    output logic               irq
);

    logic [NUM_INT-1:0] mask_eff;

`ifdef WB_MODPORT_INT_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end
    assign mask_eff = mask;
`else
    logic unused_mask_wr;
    assign unused_mask_wr = mask_we ^ (^mask_wdata);
    assign mask     = '0;
    assign mask_eff = '1;
`endif

    // An event on the clearing edge is OR'd in after the clear, so it survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (rd_clr ? '0 : pending) | evt;
            irq     <= |(pending & mask_eff);
        end
    end

endmodule

// File: rtl/wb_modport.sv
// rtl/wb_modport.sv - Wishbone register block for the MAC host port; optional WB_MODPORT_INT_MASK_EN
module wb_modport #(
    parameter int                                NUM_INT = 9,
    parameter logic [wb_modport_pkg::DATA_W-1:0] CFG_RST = wb_modport_pkg::CFG_RST
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_modport_if.slave        wb,
    input  logic [NUM_INT-1:0] int_evt_i,
    input  logic [NUM_INT-1:0] int_lvl_i,
    output logic               cfg_tx_enable_o
);

    import wb_modport_pkg::*;

    logic              accept;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] cfg_q;
    logic [DATA_W-1:0] rd_data;
    logic [NUM_INT-1:0] pending;
    logic [NUM_INT-1:0] mask;

    // Gating on ack makes a held strobe alternate accept/ack instead of double acking.
    assign accept = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign rd_en  = accept & ~wb.wb_we_i;
    assign wr_en  = accept & wb.wb_we_i;

    always_comb begin
        rd_data = '0;
        if (adr_hit(wb.wb_adr_i, ADR_CONFIG)) begin
            rd_data = cfg_q;
        end else if (adr_hit(wb.wb_adr_i, ADR_INT_PENDING)) begin
            rd_data[NUM_INT-1:0] = pending;
        end else if (adr_hit(wb.wb_adr_i, ADR_INT_STATUS)) begin
            rd_data[NUM_INT-1:0] = int_lvl_i;
        end else if (adr_hit(wb.wb_adr_i, ADR_INT_MASK)) begin
            rd_data[NUM_INT-1:0] = mask;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            cfg_q       <= CFG_RST;
        end else begin
            wb.wb_ack_o <= accept;
            if (rd_en) begin
                wb.wb_dat_o <= rd_data;
            end
            if (wr_en && adr_hit(wb.wb_adr_i, ADR_CONFIG)) begin
                cfg_q <= wb.wb_dat_i;
            end
        end
    end

    assign cfg_tx_enable_o = cfg_q[0];

    wb_modport_int_ctrl #(.NUM_INT(NUM_INT)) u_int_ctrl (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_i),
        .evt        (int_evt_i),
        .rd_clr     (rd_en & adr_hit(wb.wb_adr_i, ADR_INT_PENDING)),
        .mask_we    (wr_en & adr_hit(wb.wb_adr_i, ADR_INT_MASK)),
        .mask_wdata (wb.wb_dat_i[NUM_INT-1:0]),
        .pending    (pending),
        .mask       (mask),
        .irq        (wb.wb_int_o)
    );

endmodule

// File: tb/tb_wb_modport.sv
// tb/tb_wb_modport.sv - self-checking bench for wb_modport against a transaction-level register model
module tb_wb_modport;

    localparam int NI = 9;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic [NI-1:0] int_evt_i;
    logic [NI-1:0] int_lvl_i;
    logic          cfg_tx_enable_o;

    wb_modport_if bus ();

    wb_modport #(.NUM_INT(NI), .CFG_RST(32'h0000_0001)) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .wb              (bus),
        .int_evt_i       (int_evt_i),
        .int_lvl_i       (int_lvl_i),
        .cfg_tx_enable_o (cfg_tx_enable_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    logic [31:0]   cfg_m;
    logic [NI-1:0] pend_m;
    logic [NI-1:0] mask_m;
    logic [NI-1:0] mask_new;
    bit            clr_req;
    bit            mask_req;
    logic          exp_irq;
    logic [31:0]   last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NI-1:0] mask_eff();
`ifdef WB_MODPORT_INT_MASK_EN
        return mask_m;
`else
        return '1;
`endif
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] adr);
        case (adr >> 2)
            6'd0:    return cfg_m;
            6'd2:    return {{(32-NI){1'b0}}, pend_m};
            6'd3:    return {{(32-NI){1'b0}}, int_lvl_i};
`ifdef WB_MODPORT_INT_MASK_EN
            6'd4:    return {{(32-NI){1'b0}}, mask_m};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        cfg_m    = 32'h0000_0001;
        pend_m   = '0;
        mask_m   = '0;
        clr_req  = 1'b0;
        mask_req = 1'b0;
        last_rd  = 32'h0;
    endtask

    // One clock edge: irq out is the registered OR of pending&mask as they stood before the edge.
    task automatic tick(input logic [NI-1:0] evt);
        int_evt_i = evt;
        exp_irq   = |(pend_m & mask_eff());
        @(posedge wb_clk_i);
        #1;
        int_evt_i = '0;
        if (clr_req) pend_m = '0;
        pend_m = pend_m | evt;
        if (mask_req) mask_m = mask_new;
        clr_req  = 1'b0;
        mask_req = 1'b0;
        chk("irq", 32'(bus.wb_int_o), 32'(exp_irq));
    endtask

    task automatic bus_write(input logic [7:0] adr, input logic [31:0] d, input logic [NI-1:0] evt);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = d;
        if ((adr >> 2) == 6'd0) cfg_m = d;
        if ((adr >> 2) == 6'd4) begin
            mask_req = 1'b1;
            mask_new = d[NI-1:0];
        end
        tick(evt);
        chk("wr_ack", 32'(bus.wb_ack_o), 32'd1);
        chk("cfg_tx", 32'(cfg_tx_enable_o), 32'(cfg_m[0]));
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        tick('0);
        chk("wr_ack_drop", 32'(bus.wb_ack_o), 32'd0);
        chk("wr_dat_hold", bus.wb_dat_o, last_rd);
    endtask

    task automatic bus_read(input logic [7:0] adr, input logic [NI-1:0] evt, input string tag);
        logic [31:0] exp;
        exp = model_read(adr);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = 32'($urandom);
        if ((adr >> 2) == 6'd2) clr_req = 1'b1;
        tick(evt);
        chk("rd_ack", 32'(bus.wb_ack_o), 32'd1);
        chk(tag, bus.wb_dat_o, exp);
        last_rd = exp;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick('0);
        chk("rd_ack_drop", 32'(bus.wb_ack_o), 32'd0);
        chk("rd_dat_hold", bus.wb_dat_o, last_rd);
    endtask

    initial begin
        logic [7:0] adrs [5];
        int         n_ack;
        adrs = '{8'h00, 8'h08, 8'h0C, 8'h10, 8'h04};

        wb_rst_i     = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = '0;
        bus.wb_dat_i = '0;
        int_evt_i    = '0;
        int_lvl_i    = 9'h15A;
        mask_new     = '0;
        model_reset();

        repeat (2) @(posedge wb_clk_i);
        #1;
        chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);
        chk("rst_int", 32'(bus.wb_int_o), 32'd0);
        chk("rst_cfg_tx", 32'(cfg_tx_enable_o), 32'd1);
        wb_rst_i = 1'b1;

        bus_read(8'h00, '0, "rd_cfg_reset");
        bus_write(8'h00, 32'hA5A5_A5A4, '0);
        bus_read(8'h00, '0, "rd_cfg_a5");
        bus_write(8'h10, 32'hFFFF_FFFF, '0);
        bus_read(8'h10, '0, "rd_mask_all");

        bus_write(8'h10, 32'h0000_0004, '0);
        tick(9'h004);
        tick('0);
        bus_read(8'h08, '0, "rd_pend_4");
        bus_read(8'h08, '0, "rd_pend_cleared");

        bus_write(8'h10, 32'h0, '0);
        tick(9'h001);
        tick('0);
        bus_read(8'h08, 9'h002, "rd_pend_race");
        bus_read(8'h08, '0, "rd_pend_race_kept");

        bus_read(8'h04, '0, "rd_unmapped");
        bus_write(8'h0C, 32'hFFFF_FFFF, '0);
        bus_read(8'h0C, '0, "rd_status");
        bus_write(8'h08, 32'hFFFF_FFFF, '0);
        bus_read(8'h08, '0, "rd_pend_ro");
        bus_read(8'h00, '0, "rd_cfg_after_ro");

        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 8'h00;
        n_ack = 0;
        repeat (6) begin
            tick('0);
            if (bus.wb_ack_o) begin
                n_ack++;
                chk("held_dat", bus.wb_dat_o, cfg_m);
            end
        end
        last_rd = cfg_m;
        chk("held_acks", 32'(n_ack), 32'd3);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick('0);

        for (int i = 0; i < 60; i++) begin
            logic [7:0]    a;
            logic [NI-1:0] evt;
            a = ($urandom_range(0, 5) == 0) ? 8'($urandom) : adrs[$urandom_range(0, 4)];
            a = a | 8'($urandom_range(0, 3));
            evt = ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0;
            int_lvl_i = NI'($urandom);
            if ($urandom_range(0, 2) == 0) bus_write(a, 32'($urandom), evt);
            else bus_read(a, evt, "rd_rand");
        end

        bus_write(8'h00, 32'h0000_0000, '0);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 8'h00;
        bus.wb_dat_i = 32'hDEAD_BEEE;
        #2;
        wb_rst_i = 1'b0;
        #1;
        model_reset();
        chk("midrst_ack", 32'(bus.wb_ack_o), 32'd0);
        chk("midrst_dat", bus.wb_dat_o, 32'h0);
        chk("midrst_int", 32'(bus.wb_int_o), 32'd0);
        chk("midrst_cfg_tx", 32'(cfg_tx_enable_o), 32'd1);
        @(posedge wb_clk_i);
        #1;
        chk("midrst_no_ack", 32'(bus.wb_ack_o), 32'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        wb_rst_i = 1'b1;
        bus_read(8'h00, '0, "rd_cfg_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_modport.md
# wb_modport

Wishbone B3 classic slave register block for the 10G Ethernet MAC host port. Decodes single 32-bit register reads and writes on an 8-bit byte address. Holds the MAC configuration register and the interrupt pending, status and mask registers, and drives the level interrupt `wb_int_o`. Sits between the host Wishbone bus and the MAC core's control and status signals.

## Interface
- `NUM_INT`, default 9: number of interrupt sources, 1..32.
- `CFG_RST`, default 32'h0000_0001: reset value of the CONFIG register.

- `wb_clk_i` in 1: bus and register clock.
- `wb_rst_i` in 1: reset; asynchronous, active-low.
- `wb_adr_i` in 8: byte address; bits [1:0] are ignored.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write, 0 = read.
- `wb_dat_i` in 32: write data.
- `wb_ack_o` out 1: transfer acknowledge, one-cycle pulse.
- `wb_dat_o` out 32: read data, registered.
- `wb_int_o` out 1: interrupt request, level, registered.
- `int_evt_i` in NUM_INT: interrupt event inputs from the MAC core, one-cycle pulses, synchronous to `wb_clk_i`.
- `int_lvl_i` in NUM_INT: live condition levels from the MAC core.
- `cfg_tx_enable_o` out 1: CONFIG bit 0.

## Operation
- Register map:
  - 0x00 CONFIG: read/write, all 32 bits stored. Bit 0 drives `cfg_tx_enable_o`.
  - 0x08 INT_PENDING: read-only. Sticky event bits. The register clears on read.
  - 0x0C INT_STATUS: read-only. Returns `int_lvl_i` directly.
  - 0x10 INT_MASK: read/write, NUM_INT bits.
  - Unmapped addresses read 0. Writes to them and to read-only registers are ignored, but still acknowledged.
- Bits above NUM_INT read 0.
- A transfer is accepted when `wb_cyc_i & wb_stb_i & !wb_ack_o`.
- Pending bit i sets on an edge where `int_evt_i[i]` is 1.
- A read of INT_PENDING clears all bits at the acknowledging edge. The returned value is the value before clearing.
- If an event arrives on the same edge as the clear, the event wins and the bit stays 1.
- `wb_int_o` is registered from |(INT_PENDING & INT_MASK).

## Timing
- Reset values:
  - `wb_ack_o`=0, `wb_dat_o`=0, `wb_int_o`=0.
  - CONFIG=CFG_RST, INT_PENDING=0, INT_MASK=0.
- Latency: transfer sampled at edge N, so `wb_ack_o`=1 and `wb_dat_o` valid after edge N+1.
- Write data takes effect at edge N+1.
- `wb_ack_o` is high for exactly one cycle. A held strobe gives one ack every 2 cycles, with no double acknowledge.
- `wb_dat_o` holds its last value when no read is in progress.
- `wb_int_o` follows pending or mask changes one cycle later.
- Deasserting `wb_cyc_i` before ack: the access is dropped, with no ack and no side effect.
- Reset asserted mid-transfer: the reset values apply immediately and the transfer is lost.

## Configuration
- `WB_MODPORT_INT_MASK_EN` defined: INT_MASK is implemented as described.
- `WB_MODPORT_INT_MASK_EN` undefined:
  - No mask storage; 0x10 reads 0 and writes are ignored.
  - The mask is treated as all ones, so `wb_int_o` is |INT_PENDING registered.

## Structure
- Package `wb_modport_pkg` holds:
  - address constants `ADR_CONFIG`, `ADR_INT_PENDING`, `ADR_INT_STATUS`, `ADR_INT_MASK`;
  - the default `CFG_RST`;
  - the data and address widths.
- Sub-module `wb_modport_int_ctrl` contains the pending, mask and interrupt logic. It is driven by a read-clear strobe and a mask write strobe from the top, which does decode, ack and the read mux.

## Test plan
- Reset check: release reset, then read 0x00 -> 32'h1, ack exactly 1 cycle after strobe; `cfg_tx_enable_o`=1, `wb_int_o`=0.
- Write/read-back: write 0xA5A5_A5A4 to 0x00 -> `cfg_tx_enable_o`=0 and read-back is 0xA5A5_A5A4. Write 0xFFFF_FFFF to 0x10 -> reads 0x1FF.
- Interrupt path: mask=0x004, pulse `int_evt_i[2]` -> INT_PENDING=0x004 and `wb_int_o`=1 next cycle. A read returns 0x004; the next read returns 0 and `wb_int_o` drops.
- Masked event: mask=0, pulse `int_evt_i[0]` -> pending=0x001 and `wb_int_o` stays 0.
- Clear race: pulse `int_evt_i[1]` on the INT_PENDING read-ack edge -> the read returns the old value and bit 1 remains set afterwards.
- Bus edge cases:
  - Read 0x04 -> returns 0.
  - Write 0x0C -> no change.
  - Hold stb for 6 cycles -> 3 ack pulses.
  - Assert reset mid-transfer -> no ack.
